retire_trace_unit: RTL and testbench
====================================

# retire_trace_unit

Captures one retirement record per committed instruction in the multi-cycle custom CPU and publishes it two ways: as the 70-bit `inst_retire` bus that the simulation trace checker samples, and through a small FIFO with a valid/ready trace port for an on-chip trace sink. It sits inside the CPU, between the writeback/commit logic and the trace consumers. It pairs each commit with the PC of the instruction that produced it, even though the CPU's `PC` has already advanced by writeback.

## Interface
- `DEPTH`, 4: trace FIFO entries, power of two, 2..16.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_req_fire` in 1: `Inst_Req_Valid & Inst_Req_Ready`; marks the fetch of a new instruction.
- `pc` in 32: CPU `PC`, valid when `inst_req_fire` = 1.
- `commit` in 1: one-cycle pulse when an instruction completes, at the end of WB or the last state for non-writing instructions.
- `rf_wen` in 1: register-file write enable at commit.
- `rf_waddr` in 5: destination register at commit.
- `rf_wdata` in 32: writeback data at commit.
- `inst_retire` out 70: {rf_en[69], waddr[68:64], wdata[63:32], pc[31:0]}.
- `trace_valid` out 1: FIFO head valid.
- `trace_ready` in 1: sink accepts the head.
- `trace_data` out 70: FIFO head, same layout as `inst_retire`.
- `retire_stall` out 1: CPU must hold `commit` (only with macro).
- `drop_cnt` out `DROP_W`: count of dropped records (only without macro).

## Operation
- PC latch: on `inst_req_fire`, `ret_pc <= pc`. Holds until the next fire. Fire and commit in the same cycle: the commit uses the old `ret_pc`, and the latch updates afterwards.
- Record = {`rf_wen`, `rf_waddr`, `rf_wdata`, `ret_pc`} at `commit`.
- Writes to x0 are reported unfiltered. The consumer filters them.
- `inst_retire` update:
  - On `commit`, the register loads the record.
  - On every non-commit cycle, bit 69 clears to 0. Bits 68:0 hold their last value.
- FIFO: circular buffer with read/write pointers of width log2(`DEPTH`) and a count of width log2(`DEPTH`)+1. A push occurs on every `commit` that is accepted. A pop occurs when `trace_valid & trace_ready`.
- Full with a simultaneous pop: push and pop both proceed, and count is unchanged.
- Empty with `trace_ready`: no pop. The pointers do not move.
- Pointers wrap from `DEPTH`-1 to 0.
- `commit` is asserted at most once per instruction. Back-to-back commits on consecutive cycles must be supported.

## Timing
- `inst_retire` is registered: the record is visible in the cycle after `commit`, and bit 69 is high for exactly one cycle.
- There is no fall-through: `trace_valid` rises in the cycle after the push into an empty FIFO.
- `trace_data` is stable while `trace_valid & ~trace_ready`.
- Reset values: `inst_retire` = 0, `ret_pc` = 0, `trace_valid` = 0, `trace_data` = 0, FIFO count and pointers = 0, `retire_stall` = 0, `drop_cnt` = 0.
- Reset asserted mid-operation empties the FIFO immediately; in-flight records are discarded.

## Configuration
- `RETIRE_STALL_EN` defined:
  - `retire_stall` = (count == `DEPTH`) & ~`trace_ready`, combinational.
  - A `commit` while `retire_stall` is high is a protocol violation: the CPU holds in its commit state and re-asserts next cycle.
  - `drop_cnt` is tied to 0.
- `RETIRE_STALL_EN` undefined:
  - `retire_stall` is tied to 0.
  - A `commit` when full and not popping is dropped from the FIFO, but still appears on `inst_retire`.
  - `drop_cnt` increments by 1 per drop and saturates at all-ones.

## Structure
- Shared package `retire_pkg`: `RETIRE_W` = 70 and field offsets `RT_PC_LSB` = 0, `RT_WDATA_LSB` = 32, `RT_WADDR_LSB` = 64, `RT_RFEN_BIT` = 69, plus a packed `retire_rec_t` typedef.
- Sub-module `retire_fifo` is a generic `DEPTH`×`RETIRE_W` synchronous FIFO with push, pop, full, empty and count. The top handles the PC latch, the `inst_retire` register, stall and drop.

## Test plan
- PC pairing: fire with `pc` = 0x00000100, then 3 cycles later commit `rf_wen`=1, `waddr`=5, `wdata`=0xDEADBEEF → next cycle `inst_retire` = {1, 5, 0xDEADBEEF, 0x100}; bit 69 is 0 the cycle after that.
- Fire and commit in the same cycle: prior `ret_pc` = 0x104, new `pc` = 0x108 → record pc = 0x104; the next commit reports 0x108.
- Fill: `trace_ready`=0, 4 commits → count 4, `trace_valid`=1, head is the first record. A 5th commit: with the macro, `retire_stall`=1 and the FIFO is unchanged; without it, `drop_cnt`=1.
- Full with simultaneous push and pop: `trace_ready`=1 plus a commit → count stays 4, `retire_stall`=0, and the new record is at the tail.
- Wrap: 10 push/pop pairs with DEPTH=4 → output order matches input order, and the pointers wrapped twice.
- Reset: assert `rst` with 3 entries queued → `trace_valid`=0 and `inst_retire`=0 immediately; after release, the first commit appears as the head.

Source files
------------

// File: rtl/retire_pkg.sv
// retire_pkg: shared layout of the 70-bit retirement record.
// Record layout: {rf_en[69], waddr[68:64], wdata[63:32], pc[31:0]}.
package retire_pkg;

    localparam int RETIRE_W     = 70;
    localparam int RT_PC_LSB    = 0;
    localparam int RT_WDATA_LSB = 32;
    localparam int RT_WADDR_LSB = 64;
    localparam int RT_RFEN_BIT  = 69;

    typedef struct packed {
        logic        rf_en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } retire_rec_t;

    // Build a flat record from its fields using the named offsets.
    function automatic logic [RETIRE_W-1:0] pack_rec(
        input logic        en,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] pc
    );
        logic [RETIRE_W-1:0] r;
        r                       = '0;
        r[RT_RFEN_BIT]          = en;
        r[RT_WADDR_LSB +: 5]    = waddr;
        r[RT_WDATA_LSB +: 32]   = wdata;
        r[RT_PC_LSB +: 32]      = pc;
        return r;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// retire_fifo: generic DEPTH x WIDTH synchronous FIFO, no fall-through.
// Head data reads as zero while empty so the output is defined after reset
// without resetting the storage array.
module retire_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; data array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/retire_trace_unit.sv
// retire_trace_unit: pairs each commit with the PC of its instruction and
// publishes the record on inst_retire and through a valid/ready trace FIFO.
// Build option: define RETIRE_STALL_EN to back-pressure the CPU when the
// FIFO is full; otherwise overflowing records are dropped and counted.
module retire_trace_unit
    import retire_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_fire,
    input  logic [31:0]         pc,
    input  logic                commit,
    input  logic                rf_wen,
    input  logic [4:0]          rf_waddr,
    input  logic [31:0]         rf_wdata,
    output logic [RETIRE_W-1:0] inst_retire,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [RETIRE_W-1:0] trace_data,
    output logic                retire_stall,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      ret_pc;
    retire_rec_t      rec;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // The record always uses the PC latched before this cycle's fetch.
    assign rec         = pack_rec(rf_wen, rf_waddr, rf_wdata, ret_pc);
    assign trace_valid = ~fifo_empty;
    assign fifo_pop    = trace_valid & trace_ready;
    assign fifo_push   = commit & (~fifo_full | fifo_pop);

    // PC of the most recently fetched instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ret_pc <= '0;
        else if (inst_req_fire) ret_pc <= pc;
    end

    // Trace-checker bus: load on commit, otherwise only the enable bit drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inst_retire <= '0;
        else if (commit) inst_retire <= rec;
        else inst_retire[RT_RFEN_BIT] <= 1'b0;
    end

    retire_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RETIRE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (rec),
        .rdata (trace_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef RETIRE_STALL_EN
    assign retire_stall = (fifo_count == CNT_W'(DEPTH)) & ~trace_ready;
    assign drop_cnt     = '0;
`else
    logic drop;

    assign retire_stall = 1'b0;
    assign drop         = commit & (fifo_count == CNT_W'(DEPTH)) & ~fifo_pop;

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else if (drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_retire_trace_unit.sv
// tb_retire_trace_unit: scoreboard bench with a queue-based reference model.
module tb_retire_trace_unit;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_fire = 1'b0;
    logic [31:0] pc = '0;
    logic        commit = 1'b0;
    logic        rf_wen = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic        trace_ready = 1'b0;
    logic [69:0] inst_retire;
    logic        trace_valid;
    logic [69:0] trace_data;
    logic        retire_stall;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [69:0] exp_q[$];
    int          mdl_cnt = 0;
    logic [31:0] mdl_pc = '0;
    logic [69:0] mdl_ret = '0;
    int          mdl_drop = 0;

    always #5 clk = ~clk;

    retire_trace_unit #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_fire(inst_req_fire),
        .pc           (pc),
        .commit       (commit),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .inst_retire  (inst_retire),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_data   (trace_data),
        .retire_stall (retire_stall),
        .drop_cnt     (drop_cnt)
    );

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trace_pop: got %h expected no pop (scoreboard empty)", trace_data);
            end else begin
                chk("trace_data", trace_data, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus, called at posedge+1; returns at next posedge+1.
    task automatic step(input logic f, input logic [31:0] p, input logic c, input logic w,
                        input logic [4:0] a, input logic [31:0] d, input logic r);
        logic [69:0] recd;
        logic        pop_m;
        logic        acc;
        inst_req_fire = f; pc = p; commit = c; rf_wen = w;
        rf_waddr = a; rf_wdata = d; trace_ready = r;
        #1;
        recd  = {w, a, d, mdl_pc};
        pop_m = (mdl_cnt > 0) && r;
        acc   = c && ((mdl_cnt < DEPTH) || pop_m);
`ifdef RETIRE_STALL_EN
        chk("retire_stall_comb", {69'd0, retire_stall}, {69'd0, (mdl_cnt == DEPTH) && !r});
`else
        chk("retire_stall_tied", {69'd0, retire_stall}, 70'd0);
        if (c && !acc && mdl_drop != (1 << DROP_W) - 1) mdl_drop++;
`endif
        if (acc) exp_q.push_back(recd);
        mdl_cnt = mdl_cnt + int'(acc) - int'(pop_m);
        mdl_ret = c ? recd : {1'b0, mdl_ret[68:0]};
        if (f) mdl_pc = p;
        @(posedge clk);
        #1;
        chk("inst_retire", inst_retire, mdl_ret);
        chk("trace_valid", {69'd0, trace_valid}, {69'd0, mdl_cnt > 0});
        chk("drop_cnt", {54'd0, drop_cnt}, 70'(mdl_drop));
    endtask

    task automatic idle(input logic r);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && mdl_cnt > 0; i++) idle(1'b1);
        chk("drained", 70'(exp_q.size()), 70'd0);
    endtask

    initial begin
        logic c5;
        logic rc, cc;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_retire", inst_retire, 70'd0);
        chk("rst_trace_valid", {69'd0, trace_valid}, 70'd0);
        chk("rst_trace_data", trace_data, 70'd0);
        chk("rst_drop_cnt", {54'd0, drop_cnt}, 70'd0);
        chk("rst_stall", {69'd0, retire_stall}, 70'd0);
        rst = 1'b0;

        // PC pairing
        step(1'b1, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("pair_rec", inst_retire, {1'b1, 5'd5, 32'hDEADBEEF, 32'h100});
        idle(1'b0);
        chk("pair_bit69_clear", {69'd0, inst_retire[69]}, 70'd0);
        drain();

        // fire and commit together
        step(1'b1, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b1, 32'h108, 1'b1, 1'b1, 5'd3, 32'h11, 1'b1);
        chk("same_cycle_pc_old", 70'(inst_retire[31:0]), 70'h104);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h22, 1'b1);
        chk("same_cycle_pc_new", 70'(inst_retire[31:0]), 70'h108);
        drain();

        // fill, overflow, full push+pop
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b0);
        chk("fill_valid", {69'd0, trace_valid}, 70'd1);
        chk("fill_head", trace_data, {1'b1, 5'd1, 32'hA000, 32'h108});
`ifdef RETIRE_STALL_EN
        c5 = 1'b0;
        #1;
        chk("fill_stall", {69'd0, retire_stall}, 70'd1);
        #0;
`else
        c5 = 1'b1;
`endif
        step(1'b0, 32'h0, c5, 1'b1, 5'd9, 32'hBAD, 1'b0);
`ifndef RETIRE_STALL_EN
        chk("fill_drop", {54'd0, drop_cnt}, 70'd1);
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd10, 32'hC0DE, 1'b1);
        chk("full_pushpop_valid", {69'd0, trace_valid}, 70'd1);
        drain();

        // wrap: 10 push/pop pairs
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b1, 5'(i), 32'h5000 + 32'(i), 1'b1);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rc = 1'($urandom_range(0, 2) != 0);
            cc = 1'($urandom_range(0, 1));
`ifdef RETIRE_STALL_EN
            if (mdl_cnt == DEPTH && !rc) cc = 1'b0;
`endif
            step(1'($urandom_range(0, 1)), $urandom, cc, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom, rc);
        end
        drain();

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, 5'(i), 32'h7700 + 32'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_trace_valid", {69'd0, trace_valid}, 70'd0);
        chk("arst_inst_retire", inst_retire, 70'd0);
        exp_q.delete();
        mdl_cnt = 0;
        mdl_pc = '0;
        mdl_ret = '0;
        mdl_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 32'h4444, 1'b0);
        chk("arst_first_head", trace_data, {1'b1, 5'd4, 32'h4444, 32'h300});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
